// File: rtl/axis_block_framer_pkg.sv
// Shared helpers for the AXI-Stream block framer.
//
// cnt_width(n)   : width of an index counter for a dimension of size n,
//                  max(1, $clog2(n)) so that a size-1 dimension still has
//                  a (constant-zero) one-bit counter.
// elem_width(w)  : width of one buffered element {last, data[w-1:0]}.
//
// Packages cannot take parameters, so the element struct itself
// (elem_t {logic last; logic [WIDTH-1:0] data}) is declared next to WIDTH in
// the top module. elem_width() gives its packed width, which the skid buffer
// uses as DATA_W.
package axis_block_framer_pkg;

    function automatic int unsigned cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned elem_width(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer.
//
// The main register drives the output. The skid register catches one beat
// that was accepted while main was full and not draining. in_ready_o is
// registered: it is simply "skid empty".
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   in_data_i/valid_i      upstream beat
//   in_ready_o             upstream ready (registered)
//   out_data_o/valid_o     downstream beat (main register)
//   out_ready_i            downstream ready
module axis_skid_buffer #(
    parameter int unsigned DATA_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic in_hs;
    logic out_hs;

    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

    assign in_hs  = in_valid_i && in_ready_o;
    assign out_hs = main_valid_q && out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (out_hs) begin
            if (skid_valid_q) begin
                // Skid full means in_ready_o is low, so no input beat competes.
                main_data_d  = skid_data_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_hs) begin
                main_data_d  = in_data_i;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_hs) begin
            if (!main_valid_q) begin
                main_data_d  = in_data_i;
                main_valid_d = 1'b1;
            end else begin
                skid_data_d  = in_data_i;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/axis_block_framer.sv
// AXI-Stream block framer.
//
// Walks a BDIM0 x BDIM1 x BDIM2 block (outer to inner) over a flat input
// stream, marks the last element of every block with tlast and forwards the
// stream through a two-entry skid buffer.
//
// Ports:
//   ap_clk, ap_rst_n         clock, asynchronous active-low reset
//   s_axis_tdata/tvalid      input element
//   s_axis_tready            input ready (registered)
//   m_axis_tdata/tvalid/tlast output element with computed block-last
//   m_axis_tready            downstream ready
//   blk_count                completed blocks accepted at the input (wraps)
//   busy                     mid-block or buffer holding data
//
// Optional build macro AXIS_BLOCK_FRAMER_CHK_EN adds:
//   s_axis_tlast             upstream's own idea of block-last
//   err_align                sticky flag: upstream tlast disagreed with the
//                            computed last on some accepted element
module axis_block_framer
    import axis_block_framer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BDIM0 = 224,
    parameter int unsigned BDIM1 = 224,
    parameter int unsigned BDIM2 = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
`ifdef AXIS_BLOCK_FRAMER_CHK_EN
    input  logic             s_axis_tlast,
`endif
    output logic             s_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [CNT_W-1:0] blk_count,
`ifdef AXIS_BLOCK_FRAMER_CHK_EN
    output logic             err_align,
`endif
    output logic             busy
);

    localparam int unsigned W0 = cnt_width(int'(BDIM0));
    localparam int unsigned W1 = cnt_width(int'(BDIM1));
    localparam int unsigned W2 = cnt_width(int'(BDIM2));
    localparam int unsigned EW = elem_width(int'(WIDTH));

    localparam logic [W0-1:0] I0_MAX = W0'(BDIM0 - 1);
    localparam logic [W1-1:0] I1_MAX = W1'(BDIM1 - 1);
    localparam logic [W2-1:0] I2_MAX = W2'(BDIM2 - 1);

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } elem_t;

    logic [W0-1:0]    i0_q, i0_d;
    logic [W1-1:0]    i1_q, i1_d;
    logic [W2-1:0]    i2_q, i2_d;
    logic [CNT_W-1:0] blk_count_q, blk_count_d;

    logic  i0_max, i1_max, i2_max;
    logic  last_comb;
    logic  in_hs;
    elem_t in_elem;
    elem_t out_elem;

    assign in_hs = s_axis_tvalid && s_axis_tready;

    // A size-1 dimension has I*_MAX = 0, so its counter never leaves 0 and
    // always reads as "at maximum".
    assign i0_max    = (i0_q == I0_MAX);
    assign i1_max    = (i1_q == I1_MAX);
    assign i2_max    = (i2_q == I2_MAX);
    assign last_comb = i0_max && i1_max && i2_max;

    always_comb begin
        i0_d        = i0_q;
        i1_d        = i1_q;
        i2_d        = i2_q;
        blk_count_d = blk_count_q;

        if (in_hs) begin
            i2_d = i2_max ? '0 : i2_q + 1'b1;
            if (i2_max) begin
                i1_d = i1_max ? '0 : i1_q + 1'b1;
                if (i1_max) begin
                    i0_d = i0_max ? '0 : i0_q + 1'b1;
                end
            end
            if (last_comb) begin
                blk_count_d = blk_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            i0_q        <= '0;
            i1_q        <= '0;
            i2_q        <= '0;
            blk_count_q <= '0;
        end else begin
            i0_q        <= i0_d;
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            blk_count_q <= blk_count_d;
        end
    end

    assign in_elem.last = last_comb;
    assign in_elem.data = s_axis_tdata;

    axis_skid_buffer #(
        .DATA_W (EW)
    ) u_skid (
        .clk_i       (ap_clk),
        .rst_ni      (ap_rst_n),
        .in_data_i   (in_elem),
        .in_valid_i  (s_axis_tvalid),
        .in_ready_o  (s_axis_tready),
        .out_data_o  (out_elem),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready)
    );

    assign m_axis_tdata = out_elem.data;
    assign m_axis_tlast = out_elem.last;
    assign blk_count    = blk_count_q;

    // Skid can only be full while main is full, so !s_axis_tready never adds
    // a case on its own; it is kept to make "buffer non-empty" explicit.
    assign busy = (i0_q != '0) || (i1_q != '0) || (i2_q != '0) ||
                  m_axis_tvalid || !s_axis_tready;

`ifdef AXIS_BLOCK_FRAMER_CHK_EN
    logic err_align_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err_align_q <= 1'b0;
        end else if (in_hs && (s_axis_tlast != last_comb)) begin
            err_align_q <= 1'b1;
        end
    end

    assign err_align = err_align_q;
`endif

endmodule

// File: tb/tb_axis_block_framer.sv
module tb_axis_block_framer;

    localparam int unsigned W = 8;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic [W-1:0] s_data   = '0;
    logic         s_valid  = 1'b0;
    logic         s_tlast  = 1'b0;
    logic         m_tready = 1'b1;

    logic [4:0]   s_rdy, m_val, m_last, busy_v, err_v;
    logic [W-1:0] m_dat [5];
    logic [15:0]  blk   [5];
    logic [3:0]   blk_d;

    int sel    = 0;
    int blk_sz = 12;
    int n_in   = 0;
    int cyc    = 0;
    int nvec   = 0;
    int nerr   = 0;
    int in_cyc0 = 0;
    int out_beats = 0, out_first_cyc = 0, out_last_cyc = 0;

    logic [W:0] exp_q [$];
    logic       prev_stall = 1'b0;
    logic [W:0] prev_beat  = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // (2,2,3): main streaming and backpressure
    axis_block_framer #(.WIDTH(W), .BDIM0(2), .BDIM1(2), .BDIM2(3), .CNT_W(16)) u_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
`ifdef AXIS_BLOCK_FRAMER_CHK_EN
        .s_axis_tlast(s_tlast), .err_align(err_v[0]),
`endif
        .s_axis_tready(s_rdy[0]), .m_axis_tdata(m_dat[0]), .m_axis_tvalid(m_val[0]),
        .m_axis_tready(m_tready), .m_axis_tlast(m_last[0]), .blk_count(blk[0]),
        .busy(busy_v[0]));

    // (1,1,1): tlast on every beat
    axis_block_framer #(.WIDTH(W), .BDIM0(1), .BDIM1(1), .BDIM2(1), .CNT_W(16)) u_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
`ifdef AXIS_BLOCK_FRAMER_CHK_EN
        .s_axis_tlast(s_tlast), .err_align(err_v[1]),
`endif
        .s_axis_tready(s_rdy[1]), .m_axis_tdata(m_dat[1]), .m_axis_tvalid(m_val[1]),
        .m_axis_tready(m_tready), .m_axis_tlast(m_last[1]), .blk_count(blk[1]),
        .busy(busy_v[1]));

    // (1,3,4): mid-block reset
    axis_block_framer #(.WIDTH(W), .BDIM0(1), .BDIM1(3), .BDIM2(4), .CNT_W(16)) u_c (
        .ap_clk(clk), .ap_rst_n(rst_n), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
`ifdef AXIS_BLOCK_FRAMER_CHK_EN
        .s_axis_tlast(s_tlast), .err_align(err_v[2]),
`endif
        .s_axis_tready(s_rdy[2]), .m_axis_tdata(m_dat[2]), .m_axis_tvalid(m_val[2]),
        .m_axis_tready(m_tready), .m_axis_tlast(m_last[2]), .blk_count(blk[2]),
        .busy(busy_v[2]));

    // (1,1,2), 4-bit block counter: wrap
    axis_block_framer #(.WIDTH(W), .BDIM0(1), .BDIM1(1), .BDIM2(2), .CNT_W(4)) u_d (
        .ap_clk(clk), .ap_rst_n(rst_n), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
`ifdef AXIS_BLOCK_FRAMER_CHK_EN
        .s_axis_tlast(s_tlast), .err_align(err_v[3]),
`endif
        .s_axis_tready(s_rdy[3]), .m_axis_tdata(m_dat[3]), .m_axis_tvalid(m_val[3]),
        .m_axis_tready(m_tready), .m_axis_tlast(m_last[3]), .blk_count(blk_d),
        .busy(busy_v[3]));

    assign blk[3] = {12'd0, blk_d};

`ifdef AXIS_BLOCK_FRAMER_CHK_EN
    // (1,1,4): alignment checker
    axis_block_framer #(.WIDTH(W), .BDIM0(1), .BDIM1(1), .BDIM2(4), .CNT_W(16)) u_e (
        .ap_clk(clk), .ap_rst_n(rst_n), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
        .s_axis_tlast(s_tlast), .err_align(err_v[4]),
        .s_axis_tready(s_rdy[4]), .m_axis_tdata(m_dat[4]), .m_axis_tvalid(m_val[4]),
        .m_axis_tready(m_tready), .m_axis_tlast(m_last[4]), .blk_count(blk[4]),
        .busy(busy_v[4]));
`else
    assign err_v     = '0;
    assign s_rdy[4]  = 1'b1;
    assign m_val[4]  = 1'b0;
    assign m_last[4] = 1'b0;
    assign busy_v[4] = 1'b0;
    assign m_dat[4]  = '0;
    assign blk[4]    = '0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output monitor on the selected instance: hold rules and scoreboard pop.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", 32'(m_val[sel]), 32'd1);
                check_eq("hold_beat", 32'({m_last[sel], m_dat[sel]}), 32'(prev_beat));
            end
            if (m_val[sel] && m_tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat_qsize", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_eq("beat", 32'({m_last[sel], m_dat[sel]}), 32'(exp_q.pop_front()));
                    if (out_beats == 0) out_first_cyc = cyc;
                    out_last_cyc = cyc;
                    out_beats++;
                end
            end
            prev_stall = m_val[sel] && !m_tready;
            prev_beat  = {m_last[sel], m_dat[sel]};
        end
    end

    task automatic clear_model();
        exp_q.delete();
        n_in      = 0;
        out_beats = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_tlast = 1'b0;
        m_tready = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
    task automatic send(input logic [W-1:0] d, input logic tl);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_tlast = tl;
        while (!s_rdy[sel] && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            check_eq("in_ready_timeout", 32'(guard), 32'd0);
        end else begin
            exp_q.push_back({((n_in % blk_sz) == blk_sz - 1) ? 1'b1 : 1'b0, d});
            n_in++;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic wait_drain();
        for (int g = 0; g < 200 && exp_q.size() != 0; g++) @(posedge clk);
        #1;
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values
        sel = 0;
        blk_sz = 12;
        do_reset();
        check_eq("rst_s_ready", 32'(s_rdy[0]), 32'd1);
        check_eq("rst_m_valid", 32'(m_val[0]), 32'd0);
        check_eq("rst_m_last", 32'(m_last[0]), 32'd0);
        check_eq("rst_m_data", 32'(m_dat[0]), 32'd0);
        check_eq("rst_blk", 32'(blk[0]), 32'd0);
        check_eq("rst_busy", 32'(busy_v[0]), 32'd0);

        // (2,2,3) streaming: tlast on 11 and 23, one beat/cycle
        in_cyc0 = cyc;
        for (int k = 0; k < 24; k++) begin
            send(W'(k), 1'b0);
            if (k == 4) check_eq("a_busy_mid", 32'(busy_v[0]), 32'd1);
        end
        wait_drain();
        check_eq("a_beats", 32'(out_beats), 32'd24);
        check_eq("a_latency", 32'(out_first_cyc), 32'(in_cyc0 + 1));
        check_eq("a_last_cyc", 32'(out_last_cyc), 32'(in_cyc0 + 24));
        check_eq("a_blk", 32'(blk[0]), 32'd2);
        check_eq("a_busy_idle", 32'(busy_v[0]), 32'd0);

        // (1,1,1): tlast every beat, blk_count steps the cycle after
        sel = 1;
        blk_sz = 1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(W'(40 + k), 1'b0);
            check_eq("b_blk_step", 32'(blk[1]), 32'(k + 1));
        end
        wait_drain();
        check_eq("b_blk", 32'(blk[1]), 32'd5);

        // Backpressure: m_tready low 6 cycles with input always offered
        sel = 0;
        blk_sz = 12;
        do_reset();
        m_tready = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) send(W'(60 + k), 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                check_eq("bp_accepted", 32'(n_in), 32'd2);
                check_eq("bp_s_ready", 32'(s_rdy[0]), 32'd0);
                check_eq("bp_busy", 32'(busy_v[0]), 32'd1);
                m_tready = 1'b1;
            end
        join
        wait_drain();
        check_eq("bp_beats", 32'(out_beats), 32'd8);
        check_eq("bp_blk", 32'(blk[0]), 32'd0);

        // (1,3,4): reset after 7 elements, then a fresh block
        sel = 2;
        blk_sz = 12;
        do_reset();
        for (int k = 0; k < 7; k++) send(W'(200 + k), 1'b0);
        rst_n = 1'b0;
        clear_model();
        #1;
        check_eq("c_rst_busy", 32'(busy_v[2]), 32'd0);
        check_eq("c_rst_valid", 32'(m_val[2]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 12; k++) begin
            send(W'(100 + k), 1'b0);
            if (k == 10) check_eq("c_blk_pre", 32'(blk[2]), 32'd0);
        end
        wait_drain();
        check_eq("c_beats", 32'(out_beats), 32'd12);
        check_eq("c_blk", 32'(blk[2]), 32'd1);

        // (1,1,2), CNT_W=4: 17 blocks wrap to 1
        sel = 3;
        blk_sz = 2;
        do_reset();
        for (int k = 0; k < 34; k++) begin
            send(W'(k * 3), 1'b0);
            if (k == 31) check_eq("d_blk_full", 32'(blk[3]), 32'd0);
        end
        wait_drain();
        check_eq("d_blk_wrap", 32'(blk[3]), 32'd1);

`ifdef AXIS_BLOCK_FRAMER_CHK_EN
        // (1,1,4): upstream tlast on the 3rd element
        sel = 4;
        blk_sz = 4;
        do_reset();
        check_eq("e_err_rst", 32'(err_v[4]), 32'd0);
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        check_eq("e_err_before", 32'(err_v[4]), 32'd0);
        send(8'd3, 1'b1);
        check_eq("e_err_set", 32'(err_v[4]), 32'd1);
        send(8'd4, 1'b0);
        check_eq("e_err_sticky", 32'(err_v[4]), 32'd1);
        wait_drain();
        check_eq("e_err_hold", 32'(err_v[4]), 32'd1);
        check_eq("e_blk", 32'(blk[4]), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
